// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter with bounded burst lock that shares one FIFO write port among NUM_REQ requesters.
// Define FPA_STALL_CNT_EN to add stall_cnt, a saturating count of grant cycles stalled by fifo_full.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FPA_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         last_grant, last_grant_nxt, grant_nxt, sel_id, idx;
  logic [CW-1:0]         beat_cnt, beat_cnt_nxt;
  logic                  sel_found, valid_g, xfer;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : gen_slice
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign valid_g = req_valid[grant_id];
  assign busy    = (state == GRANT);

  // Rotating priority: scan starts just after the last released requester.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    req_ready      = '0;
    fifo_push      = 1'b0;
    fifo_wr_data   = '0;
    xfer           = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt    = sel_id;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id] = !fifo_full;
        xfer                = valid_g && !fifo_full;
        fifo_push           = xfer;
        fifo_wr_data        = data_arr[grant_id];
        if (xfer) beat_cnt_nxt = beat_cnt + CW'(1);
        // A full-FIFO stall keeps the grant; only an idle requester or the burst limit releases it.
        if (!valid_g || (xfer && beat_cnt == CW'(MAX_BURST - 1))) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

`ifdef FPA_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == GRANT && valid_g && fifo_full && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  push_safe: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: directed bursts, stalls, release, async reset and random traffic.
module tb_fifo_push_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_push;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0]    grant_id;
  logic          busy;
`ifdef FPA_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
`ifdef FPA_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int gid; int data; int cyc;} exp_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t0;
  bit         rnd_mode = 1'b0;
  logic [N-1:0] en = '0;
  logic [7:0] drv_q [N][$];
  logic [7:0] rexp_q [N][$];
  exp_t       exp_q [$];
  int         wait_cnt [N];
  logic       prev_busy = 1'b0;
  logic [N-1:0] prev_valid = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_push(input int g, input int d, input int c);
    exp_t e;
    e.gid = g; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (drv_q[i].size() > 0);
      req_data[i*DW +: DW] = (drv_q[i].size() > 0) ? drv_q[i][0] : 8'h00;
    end
  endtask

  // Requester model: pop a word once its handshake completed on the edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(drv_q[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      rexp_q[i].delete();
      wait_cnt[i] = 0;
    end
    exp_q.delete();
    drive();
    @(posedge clk);
    #2;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_push", int'(fifo_push), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_wdata", int'(fifo_wr_data), 0);
`ifdef FPA_STALL_CNT_EN
    chk("rst_stall_cnt", int'(stall_cnt), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every push is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (fifo_full) chk("push_while_full", int'(fifo_push), 0);
      if (!busy) chk("push_in_idle", int'(fifo_push), 0);
      if (fifo_push && !rnd_mode) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_push: got data %0h gid %0d expected no push (cycle %0d)",
                   fifo_wr_data, grant_id, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gid", int'(grant_id), e.gid);
          chk("sb_data", int'(fifo_wr_data), e.data);
          chk("sb_cycle", cyc, e.cyc);
        end
      end
      if (rnd_mode) begin
        if (fifo_push) begin
          if (rexp_q[grant_id].size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rnd_extra_push: got data %0h gid %0d expected no push", fifo_wr_data, grant_id);
          end else begin
            chk("rnd_data", int'(fifo_wr_data), int'(rexp_q[grant_id].pop_front()));
          end
        end
        if (busy && !prev_busy) begin
          for (int i = 0; i < N; i++) begin
            if (i == int'(grant_id)) wait_cnt[i] = 0;
            else if (prev_valid[i]) begin
              wait_cnt[i]++;
              chk("starvation", int'(wait_cnt[i] > N - 1), 0);
            end
          end
        end
        for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      end
    end
    prev_busy = busy;
    prev_valid = req_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    // 1: single requester, burst limit then re-grant
    do_reset();
    for (int k = 0; k < 6; k++) drv_q[0].push_back(8'(8'hA0 + k));
    en = 4'b0001; drive(); t0 = cyc;
    for (int k = 0; k < 4; k++) expect_push(0, 8'hA0 + k, t0 + 1 + k);
    expect_push(0, 8'hA4, t0 + 6);
    expect_push(0, 8'hA5, t0 + 7);
    #1 chk("t1_busy_c0", int'(busy), 0);
    tick(); #1;
    chk("t1_grant_c1", int'(grant_id), 0);
    chk("t1_busy_c1", int'(busy), 1);
    repeat (7) tick();
    #1 chk("t1_busy_c8", int'(busy), 1);
    tick();
    #1 chk("t1_busy_c9", int'(busy), 0);
    chk("t1_drain", exp_q.size(), 0);

    // 2: all requesters valid, round-robin 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 8; k++) drv_q[0].push_back(8'(k));
    for (int g = 1; g < N; g++) for (int k = 0; k < 4; k++) drv_q[g].push_back(8'(16 * g + k));
    en = 4'b1111; drive(); t0 = cyc;
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++)
        expect_push(b % 4, 16 * (b % 4) + (b == 4 ? 4 : 0) + k, t0 + 5 * b + 1 + k);
    for (int c = 1; c <= 26; c++) begin
      tick(); #1;
      if (c % 5 == 1 && c < 25) chk("t2_grant", int'(grant_id), (c / 5) % 4);
      if ((c % 5 == 0 && c < 25) || c == 26) chk("t2_idle_busy", int'(busy), 0);
    end
    chk("t2_drain", exp_q.size(), 0);

    // 3: requester 2 stalled by full for 5 cycles mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) drv_q[2].push_back(8'(8'hC0 + k));
    en = 4'b0100; drive(); t0 = cyc;
    expect_push(2, 8'hC0, t0 + 1);
    expect_push(2, 8'hC1, t0 + 2);
    expect_push(2, 8'hC2, t0 + 8);
    expect_push(2, 8'hC3, t0 + 9);
    repeat (3) tick();
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t3_stall_ready", int'(req_ready), 0);
      chk("t3_stall_push", int'(fifo_push), 0);
      chk("t3_stall_grant", int'(grant_id), 2);
      tick();
    end
    fifo_full = 1'b0;
    #1 chk("t3_resume_ready", int'(req_ready), 4);
    repeat (3) tick();
    #1 chk("t3_busy_end", int'(busy), 0);
`ifdef FPA_STALL_CNT_EN
    chk("t3_stall_cnt", int'(stall_cnt), 5);
`endif
    chk("t3_drain", exp_q.size(), 0);

    // 4: requester 1 drops valid after 2 beats; 3 then precedes 0
    do_reset();
    drv_q[1].push_back(8'hB0); drv_q[1].push_back(8'hB1);
    drv_q[3].push_back(8'hD0); drv_q[3].push_back(8'hD1);
    drv_q[0].push_back(8'hE0);
    en = 4'b1010; drive(); t0 = cyc;
    expect_push(1, 8'hB0, t0 + 1);
    expect_push(1, 8'hB1, t0 + 2);
    expect_push(3, 8'hD0, t0 + 5);
    expect_push(3, 8'hD1, t0 + 6);
    expect_push(0, 8'hE0, t0 + 9);
    tick();
    en = 4'b1011; drive();
    tick(); tick(); #1;
    chk("t4_release_grant", int'(grant_id), 1);
    chk("t4_release_busy", int'(busy), 1);
    tick(); tick(); #1;
    chk("t4_next_grant", int'(grant_id), 3);
    repeat (4) tick(); #1;
    chk("t4_last_grant", int'(grant_id), 0);
    repeat (2) tick();
    chk("t4_drain", exp_q.size(), 0);

    // 5: async reset mid-burst, then fresh arbitration
    do_reset();
    for (int k = 0; k < 4; k++) drv_q[2].push_back(8'(8'hF0 + k));
    en = 4'b0100; drive(); t0 = cyc;
    expect_push(2, 8'hF0, t0 + 1);
    tick(); tick(); #1;
    chk("t5_pre_grant", int'(grant_id), 2);
    chk("t5_pre_ready", int'(req_ready), 4);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", int'(req_ready), 0);
    chk("t5_rst_push", int'(fifo_push), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_grant", int'(grant_id), 0);
    chk("t5_drop", exp_q.size(), 0);
    drv_q[2].delete();
    drv_q[3].push_back(8'h5A);
    en = 4'b1000;
    tick();
    rst_n = 1'b1; t0 = cyc;
    expect_push(3, 8'h5A, t0 + 1);
    tick(); #1;
    chk("t5_regrant", int'(grant_id), 3);
    chk("t5_regrant_busy", int'(busy), 1);
    repeat (3) tick();
    chk("t5_drain", exp_q.size(), 0);

    // 6: random valid/full traffic
    do_reset();
    rnd_mode = 1'b1;
    en = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (drv_q[i].size() < 3 && $urandom_range(0, 2) == 0) begin
          d = 8'($urandom);
          drv_q[i].push_back(d);
          rexp_q[i].push_back(d);
        end
      end
      drive();
      tick();
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (drv_q[0].size() + drv_q[1].size() + drv_q[2].size() + drv_q[3].size() == 0) break;
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < N; i++) chk("rnd_drain", rexp_q[i].size(), 0);
    rnd_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
